// File: rtl/isa_superio_pkg.sv
// Shared types and constants for the ISA SuperIO bridge.
// Channel index, scheduler state and DRQ/DACK bit order.
package isa_superio_pkg;

   localparam int unsigned NUM_CH = 4;

   localparam int unsigned DRQ1_BIT = 0;
   localparam int unsigned DRQ3_BIT = 1;
   localparam int unsigned DRQ5_BIT = 2;
   localparam int unsigned DRQ7_BIT = 3;

   typedef logic [1:0] ch_t;

   localparam ch_t CH_LAST = ch_t'(DRQ7_BIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOST,
      S_SETUP,
      S_CYCLE,
      S_HOLD,
      S_RECOVER
   } sched_state_t;

endpackage

// File: rtl/isa_dma_rr_arbiter.sv
// Rotating-priority pick among four DMA requests.
// The channel after last_ch has highest priority.
module isa_dma_rr_arbiter
   import isa_superio_pkg::*;
(
   input  logic [3:0] req,
   input  ch_t        last_ch,
   output ch_t        ch,
   output logic       valid
);

   always_comb begin
      valid = |req;
      ch    = last_ch;
      // Walk from farthest to nearest so the nearest set bit wins.
      for (int i = int'(NUM_CH); i >= 1; i--) begin
         if (req[ch_t'(last_ch + ch_t'(i))]) begin
            ch = ch_t'(last_ch + ch_t'(i));
         end
      end
   end

endmodule

// File: rtl/isa_dma_scheduler.sv
// Host PIO / ISA DMA scheduler for the shared ISA cycle engine.
// Synchronises DRQ, arbitrates, drives DACK and counts transfers.
module isa_dma_scheduler
   import isa_superio_pkg::*;
#(
   parameter int unsigned SETUP_CYC   = 4,
   parameter int unsigned HOLD_CYC    = 2,
   parameter int unsigned RECOVER_CYC = 8,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  drq,
   input  logic        host_req,
   output logic        host_gnt,
   input  logic        cfg_wr,
   input  logic [1:0]  cfg_ch,
   input  logic [15:0] cfg_count,
   input  logic        cfg_dir,
   input  logic        cfg_en,
   output logic [3:0]  dack,
   output logic        cyc_req,
   output logic        cyc_dir,
   input  logic        cyc_done,
   output logic [3:0]  tc,
   output logic        timeout,
   output logic        busy
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

   sched_state_t    state;
   logic [3:0]      drq_m;
   logic [3:0]      drq_q;
   logic [3:0]      drq_s;
   logic [3:0]      en;
   logic [3:0]      dir;
   logic [15:0]     count [NUM_CH];
   ch_t             cur_ch;
   ch_t             last_ch;
   ch_t             pick_ch;
   logic            pick_valid;
   logic            last_dma;
   logic [15:0]     phase;
   logic [WD_W-1:0] wd;
   logic            wd_exp;
   logic            done_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drq_m <= '0;
         drq_q <= '0;
      end else begin
         drq_m <= drq;
         drq_q <= drq_m;
      end
   end

   assign drq_s   = drq_q & en;
   assign wd_exp  = (wd == WD_W'(TIMEOUT_CYC - 1));
   assign done_ok = (state == S_CYCLE) && cyc_done;
   assign busy    = (state != S_IDLE);

   isa_dma_rr_arbiter u_arb (
      .req     (drq_s),
      .last_ch (last_ch),
      .ch      (pick_ch),
      .valid   (pick_valid)
   );

   // A config write to the active channel overrides its decrement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en  <= '0;
         dir <= '0;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            count[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cfg_wr && cfg_ch == ch_t'(i)) begin
               count[i] <= cfg_count;
               dir[i]   <= cfg_dir;
               en[i]    <= cfg_en;
            end else if (done_ok && cur_ch == ch_t'(i)) begin
               if (count[i] == 16'd0) begin
                  en[i] <= 1'b0;
               end else begin
                  count[i] <= count[i] - 16'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         dack     <= '0;
         host_gnt <= 1'b0;
         cyc_req  <= 1'b0;
         cyc_dir  <= 1'b0;
         tc       <= '0;
         timeout  <= 1'b0;
         cur_ch   <= '0;
         last_ch  <= CH_LAST;
         last_dma <= 1'b0;
         phase    <= '0;
         wd       <= '0;
      end else begin
         host_gnt <= 1'b0;
         cyc_req  <= 1'b0;
         tc       <= '0;
         timeout  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               phase <= '0;
               wd    <= '0;
               if (host_req && (last_dma || !(|drq_s))) begin
                  host_gnt <= 1'b1;
                  last_dma <= 1'b0;
                  state    <= S_HOST;
               end else if (pick_valid) begin
                  dack     <= 4'(1) << pick_ch;
                  cur_ch   <= pick_ch;
                  cyc_dir  <= dir[pick_ch];
                  last_dma <= 1'b1;
                  state    <= S_SETUP;
               end
            end
            S_HOST: begin
               if (cyc_done) begin
                  state <= S_RECOVER;
               end else if (wd_exp) begin
                  timeout <= 1'b1;
                  state   <= S_RECOVER;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            S_SETUP: begin
               if (phase == 16'(SETUP_CYC - 1)) begin
                  cyc_req <= 1'b1;
                  phase   <= '0;
                  wd      <= '0;
                  state   <= S_CYCLE;
               end else begin
                  phase <= phase + 16'd1;
               end
            end
            S_CYCLE: begin
               if (cyc_done) begin
                  if (count[cur_ch] == 16'd0) begin
                     tc[cur_ch] <= 1'b1;
                  end
                  phase <= '0;
                  state <= S_HOLD;
               end else if (wd_exp) begin
                  timeout <= 1'b1;
                  dack    <= '0;
                  last_ch <= cur_ch;
                  phase   <= '0;
                  state   <= S_RECOVER;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            S_HOLD: begin
               if (phase == 16'(HOLD_CYC - 1)) begin
                  dack    <= '0;
                  last_ch <= cur_ch;
                  phase   <= '0;
                  state   <= S_RECOVER;
               end else begin
                  phase <= phase + 16'd1;
               end
            end
            S_RECOVER: begin
               if (phase == 16'(RECOVER_CYC - 1)) begin
                  phase <= '0;
                  state <= S_IDLE;
               end else begin
                  phase <= phase + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_isa_dma_scheduler.sv
// Scoreboard bench for isa_dma_scheduler: grant order, tc,
// latencies, timeout, reset abort and disabled channels.
module tb_isa_dma_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  drq = '0;
   logic        host_req = 1'b0;
   logic        host_gnt;
   logic        cfg_wr = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [15:0] cfg_count = '0;
   logic        cfg_dir = 1'b0;
   logic        cfg_en = 1'b0;
   logic [3:0]  dack;
   logic        cyc_req;
   logic        cyc_dir;
   logic        cyc_done = 1'b0;
   logic [3:0]  tc;
   logic        timeout;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   int grant_q[$];
   int tc_q[$];
   bit exp_dir[4];

   int gcount = 0;
   int n_req  = 0;
   int n_to   = 0;
   int cyc    = 0;
   int t_dack = 0;
   int t_req  = 0;
   logic [3:0] prev_dack = '0;
   int eng_cnt   = 0;
   int host_left = 0;
   bit withhold  = 1'b0;
   int mk;
   int mexp;

   always #5 clk = ~clk;

   isa_dma_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .drq       (drq),
      .host_req  (host_req),
      .host_gnt  (host_gnt),
      .cfg_wr    (cfg_wr),
      .cfg_ch    (cfg_ch),
      .cfg_count (cfg_count),
      .cfg_dir   (cfg_dir),
      .cfg_en    (cfg_en),
      .dack      (dack),
      .cyc_req   (cyc_req),
      .cyc_dir   (cyc_dir),
      .cyc_done  (cyc_done),
      .tc        (tc),
      .timeout   (timeout),
      .busy      (busy)
   );

   task automatic check(string tag, int obs, int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int oh2i(logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // Cycle engine and host model.
   always @(negedge clk) begin
      cyc_done = 1'b0;
      if (reset) begin
         eng_cnt = 0;
      end else if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) cyc_done = 1'b1;
      end else if ((cyc_req || host_gnt) && !withhold) begin
         eng_cnt = 3;
      end
      if (host_gnt && host_left > 0) host_left--;
      host_req = (host_left > 0) && !reset;
   end

   // Monitor: pops the scoreboard as the DUT produces events.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         prev_dack = '0;
      end else begin
         if (prev_dack == 4'd0 && dack != 4'd0) begin
            gcount++;
            t_dack = cyc;
            mexp = (grant_q.size() > 0) ? grant_q.pop_front() : 99;
            check("grant", oh2i(dack), mexp);
         end
         if (host_gnt) begin
            gcount++;
            mexp = (grant_q.size() > 0) ? grant_q.pop_front() : 99;
            check("grant", 4, mexp);
         end
         if (cyc_req) begin
            n_req++;
            t_req = cyc;
            check("setup_lat", cyc - t_dack, 4);
            mk = oh2i(dack);
            check("req_dack", int'(mk >= 0), 1);
            if (mk >= 0) check("cyc_dir", int'(cyc_dir), int'(exp_dir[mk]));
         end
         if (tc != 4'd0) begin
            mexp = (tc_q.size() > 0) ? tc_q.pop_front() : -99;
            check("tc", gcount * 4 + oh2i(tc), mexp);
         end
         if (timeout) begin
            n_to++;
            check("to_lat", cyc - t_req, 4096);
            check("to_dack", int'(dack), 0);
         end
         prev_dack = dack;
      end
   end

   task automatic do_reset();
      drq       = '0;
      host_left = 0;
      withhold  = 1'b0;
      cfg_wr    = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic cfg(int ch, int cnt, bit d, bit e);
      @(negedge clk);
      cfg_wr    = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_count = 16'(cnt);
      cfg_dir   = d;
      cfg_en    = e;
      exp_dir[ch] = d;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   task automatic wait_grants(int target, int budget, string tag);
      int n = 0;
      while (gcount < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, int'(gcount >= target), 1);
   endtask

   int b;
   int r0;
   int t0;

   initial begin
      // Reset state
      @(negedge clk);
      check("rst_dack", int'(dack), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_gnt", int'(host_gnt), 0);
      check("rst_req", int'(cyc_req), 0);
      check("rst_tc", int'(tc), 0);
      check("rst_to", int'(timeout), 0);
      reset = 1'b0;
      @(negedge clk);

      // Single channel, three transfers, tc on the third
      cfg(0, 2, 1'b1, 1'b1);
      b  = gcount;
      r0 = n_req;
      grant_q.push_back(0);
      grant_q.push_back(0);
      grant_q.push_back(0);
      tc_q.push_back((b + 3) * 4 + 0);
      @(negedge clk);
      drq[0] = 1'b1;
      repeat (2) @(negedge clk);
      check("drq_lat_early", int'(dack), 0);
      @(negedge clk);
      check("drq_lat", int'(dack), 1);
      wait_grants(b + 3, 200, "t1_grants");
      repeat (80) @(negedge clk);
      check("t1_reqs", n_req - r0, 3);
      check("t1_dis_dack", int'(dack), 0);
      check("t1_dis_busy", int'(busy), 0);
      check("t1_tcq", tc_q.size(), 0);

      // Two channels alternate
      do_reset();
      cfg(0, 1, 1'b0, 1'b1);
      cfg(3, 1, 1'b1, 1'b1);
      b = gcount;
      grant_q.push_back(0);
      grant_q.push_back(3);
      grant_q.push_back(0);
      grant_q.push_back(3);
      tc_q.push_back((b + 3) * 4 + 0);
      tc_q.push_back((b + 4) * 4 + 3);
      drq = 4'b1001;
      wait_grants(b + 4, 400, "t2_grants");
      repeat (60) @(negedge clk);
      drq = '0;
      check("t2_q", grant_q.size(), 0);

      // Host and DMA alternate
      do_reset();
      cfg(1, 5, 1'b0, 1'b1);
      b = gcount;
      grant_q.push_back(1);
      grant_q.push_back(4);
      grant_q.push_back(1);
      grant_q.push_back(4);
      grant_q.push_back(1);
      drq[1] = 1'b1;
      wait_grants(b + 1, 100, "t3_first");
      host_left = 2;
      wait_grants(b + 5, 400, "t3_grants");
      drq = '0;
      repeat (60) @(negedge clk);
      check("t3_q", grant_q.size(), 0);
      check("t3_busy", int'(busy), 0);

      // Timeout keeps the count
      do_reset();
      cfg(2, 1, 1'b0, 1'b1);
      b  = gcount;
      t0 = n_to;
      withhold = 1'b1;
      grant_q.push_back(2);
      grant_q.push_back(2);
      grant_q.push_back(2);
      tc_q.push_back((b + 3) * 4 + 2);
      drq[2] = 1'b1;
      for (int n = 0; n < 5000 && n_to == t0; n++) @(negedge clk);
      check("t4_timeout", n_to - t0, 1);
      withhold = 1'b0;
      wait_grants(b + 3, 300, "t4_grants");
      repeat (60) @(negedge clk);
      drq = '0;
      check("t4_q", grant_q.size() + tc_q.size(), 0);

      // Reset mid-cycle
      do_reset();
      cfg(0, 0, 1'b1, 1'b1);
      r0 = n_req;
      withhold = 1'b1;
      grant_q.push_back(0);
      drq[0] = 1'b1;
      for (int n = 0; n < 100 && n_req == r0; n++) @(negedge clk);
      check("t5_req", n_req - r0, 1);
      repeat (3) @(negedge clk);
      check("t5_dack_pre", int'(dack), 1);
      #2 reset = 1'b1;
      #1;
      check("t5_dack", int'(dack), 0);
      check("t5_busy", int'(busy), 0);
      @(negedge clk);
      reset    = 1'b0;
      withhold = 1'b0;
      drq      = '0;
      repeat (40) @(negedge clk);
      check("t5_tc", tc_q.size() + grant_q.size(), 0);

      // Disabled channel ignored
      do_reset();
      cfg(2, 0, 1'b0, 1'b0);
      drq = 4'b0100;
      for (int n = 0; n < 4; n++) begin
         repeat (10) @(negedge clk);
         check("t6_dack", int'(dack), 0);
         check("t6_busy", int'(busy), 0);
      end
      drq = '0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
